// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug register reader: sizes, FSM states,
// response beat layout and the last-beat helper.
package dbg_pkg;

  localparam int DBG_XLEN   = 64;
  localparam int DBG_NREGS  = 32;
  localparam int DBG_AWIDTH = $clog2(DBG_NREGS);

  typedef enum logic [0:0] {
    DBG_IDLE = 1'b0,
    DBG_DUMP = 1'b1
  } dbg_state_e;

  typedef struct packed {
    logic [DBG_AWIDTH-1:0] addr;
    logic [DBG_XLEN-1:0]   data;
    logic [DBG_XLEN-1:0]   pc;
    logic                  last;
  } dbg_rsp_t;

  // True for the final register index of a dump sequence.
  function automatic logic dbg_is_last(input logic [DBG_AWIDTH-1:0] idx);
    return (idx == DBG_AWIDTH'(DBG_NREGS - 1));
  endfunction

endpackage

// File: rtl/dbg_reg_reader_if.sv
// Debug host <-> register reader bus: request channel, response stream and dump status.
interface dbg_reg_reader_if import dbg_pkg::*; #(
  parameter int XLEN = DBG_XLEN,
  parameter int AW   = DBG_AWIDTH
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_dump;
  logic [AW-1:0]   req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [AW-1:0]   rsp_addr;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] rsp_pc;
  logic            rsp_last;
  logic            dump_busy;

  modport master (
    output req_valid, req_dump, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_pc, rsp_last, dump_busy
  );

  modport slave (
    input  req_valid, req_dump, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_pc, rsp_last, dump_busy
  );

endinterface

// File: rtl/dbg_shadow_rf.sv
// Shadow copy of the GPR file plus the PC of each register's last write.
// One write port from writeback, one combinational read port with same-cycle bypass.
module dbg_shadow_rf import dbg_pkg::*; #(
  parameter int XLEN  = DBG_XLEN,
  parameter int NREGS = DBG_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] rd_pc
);

  logic [XLEN-1:0] data_r [NREGS];
  logic [XLEN-1:0] pc_r   [NREGS];

  // Shadow array update; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        data_r[i] <= {XLEN{1'b0}};
        pc_r[i]   <= {XLEN{1'b0}};
      end
    end else if (wb_rd != {AW{1'b0}}) begin
      data_r[wb_rd] <= wb_data;
      pc_r[wb_rd]   <= wb_pc;
    end else begin
      data_r <= data_r;
      pc_r   <= pc_r;
    end
  end

  // Read port: x0 hardwired to zero, a same-cycle write to the read register wins.
  always_comb begin
    rd_data = {XLEN{1'b0}};
    rd_pc   = {XLEN{1'b0}};
    if (rd_addr == {AW{1'b0}}) begin
      rd_data = {XLEN{1'b0}};
      rd_pc   = {XLEN{1'b0}};
    end else if (rd_addr == wb_rd) begin
      rd_data = wb_data;
      rd_pc   = wb_pc;
    end else begin
      rd_data = data_r[rd_addr];
      rd_pc   = pc_r[rd_addr];
    end
  end

endmodule

// File: rtl/dbg_reg_reader.sv
// Debug register reader: serves single-register reads and full dumps of the shadow
// register file over a valid/ready response stream with a single holding register.
module dbg_reg_reader import dbg_pkg::*; #(
  parameter int XLEN  = DBG_XLEN,
  parameter int NREGS = DBG_NREGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  dbg_reg_reader_if.slave          dbg
);

  localparam int AW = $clog2(NREGS);

  dbg_state_e      state_r, state_nxt_s;
  logic [AW-1:0]   cnt_r, cnt_nxt_s;
  logic            dump_busy_r, dump_busy_nxt_s;
  dbg_rsp_t        rsp_r, rsp_nxt_s;
  logic            rsp_valid_r, rsp_valid_nxt_s;
  logic            load_en_s, load_s, last_s, req_ready_s;
  logic [AW-1:0]   rd_addr_s;
  logic [XLEN-1:0] rd_data_s, rd_pc_s;

  dbg_shadow_rf #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_shadow_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_rd   (wb_rd),
    .wb_pc   (wb_pc),
    .wb_data (wb_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s),
    .rd_pc   (rd_pc_s)
  );

  assign load_en_s = !rsp_valid_r || dbg.rsp_ready;

  // FSM next state, dump counter and beat-load decision.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    dump_busy_nxt_s = dump_busy_r;
    req_ready_s     = 1'b0;
    rd_addr_s       = cnt_r;
    load_s          = 1'b0;
    last_s          = 1'b0;
    case (state_r)
      DBG_IDLE: begin
        req_ready_s = load_en_s;
        if (dbg.req_valid && load_en_s) begin
          if (dbg.req_dump) begin
            state_nxt_s     = DBG_DUMP;
            cnt_nxt_s       = {AW{1'b0}};
            dump_busy_nxt_s = 1'b1;
          end else begin
            rd_addr_s = dbg.req_addr;
            load_s    = 1'b1;
            last_s    = 1'b1;
          end
        end else begin
          state_nxt_s = DBG_IDLE;
        end
      end
      DBG_DUMP: begin
        if (load_en_s) begin
          load_s    = 1'b1;
          last_s    = dbg_is_last(cnt_r);
          cnt_nxt_s = cnt_r + AW'(1);
          // Final beat: leave the counter parked at zero rather than wrapping.
          if (dbg_is_last(cnt_r)) begin
            state_nxt_s     = DBG_IDLE;
            cnt_nxt_s       = {AW{1'b0}};
            dump_busy_nxt_s = 1'b0;
          end else begin
            state_nxt_s = DBG_DUMP;
          end
        end else begin
          state_nxt_s = DBG_DUMP;
        end
      end
      default: begin
        state_nxt_s     = DBG_IDLE;
        cnt_nxt_s       = {AW{1'b0}};
        dump_busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output holding register: load replaces, handshake without load empties, stall holds.
  always_comb begin
    rsp_nxt_s       = rsp_r;
    rsp_valid_nxt_s = rsp_valid_r;
    if (load_s) begin
      rsp_valid_nxt_s = 1'b1;
      rsp_nxt_s.addr  = rd_addr_s;
      rsp_nxt_s.data  = rd_data_s;
      rsp_nxt_s.pc    = rd_pc_s;
      rsp_nxt_s.last  = last_s;
    end else if (load_en_s) begin
      rsp_valid_nxt_s = 1'b0;
    end else begin
      rsp_valid_nxt_s = rsp_valid_r;
    end
  end

  // State, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DBG_IDLE;
      cnt_r       <= {AW{1'b0}};
      dump_busy_r <= 1'b0;
      rsp_r       <= '{addr: {AW{1'b0}}, data: {XLEN{1'b0}}, pc: {XLEN{1'b0}}, last: 1'b0};
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      dump_busy_r <= dump_busy_nxt_s;
      rsp_r       <= rsp_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
    end
  end

  assign dbg.req_ready = req_ready_s;
  assign dbg.rsp_valid = rsp_valid_r;
  assign dbg.rsp_addr  = rsp_r.addr;
  assign dbg.rsp_data  = rsp_r.data;
  assign dbg.rsp_pc    = rsp_r.pc;
  assign dbg.rsp_last  = rsp_r.last;
  assign dbg.dump_busy = dump_busy_r;

endmodule

// File: tb/tb_dbg_reg_reader.sv
// Scoreboard bench for dbg_reg_reader: directed stimulus pushes expected beats,
// a negedge monitor pops and compares every consumed response beat.
module tb_dbg_reg_reader;

  logic        clk;
  logic        rst_n;
  logic [63:0] wb_pc;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  dbg_reg_reader_if #(.XLEN(64), .AW(5)) dbg ();

  dbg_reg_reader #(.XLEN(64), .NREGS(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_pc   (wb_pc),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .dbg     (dbg)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic [63:0] pc;
    logic        last;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [63:0] m_data [32];
  logic [63:0] m_pc   [32];
  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d, input logic [63:0] p,
                      input logic l, input logic b);
    exp_t e;
    e.addr = a; e.data = d; e.pc = p; e.last = l; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++)
      push(5'(i), m_data[i], m_pc[i], (i == 31), (i != 31));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 64'h0;
      m_pc[i]   = 64'h0;
    end
  endtask

  // Monitor: every consumed beat is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && dbg.rsp_valid && dbg.rsp_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %0d expected no beat", dbg.rsp_addr);
      end else begin
        cur = exp_q.pop_front();
        chk("rsp_addr", 64'(dbg.rsp_addr), 64'(cur.addr));
        chk("rsp_data", dbg.rsp_data, cur.data);
        chk("rsp_pc",   dbg.rsp_pc,   cur.pc);
        chk("rsp_last", 64'(dbg.rsp_last), 64'(cur.last));
        chk("dump_busy_beat", 64'(dbg.dump_busy), 64'(cur.busy));
      end
    end
  end

  task automatic wb_write(input logic [4:0] rd, input logic [63:0] d, input logic [63:0] p);
    wb_rd = rd; wb_data = d; wb_pc = p;
    if (rd != 5'd0) begin
      m_data[rd] = d;
      m_pc[rd]   = p;
    end
    @(posedge clk); #1;
    wb_rd = 5'd0; wb_data = 64'h0; wb_pc = 64'h0;
  endtask

  task automatic send_req(input logic dump, input logic [4:0] addr);
    int n;
    n = 0;
    dbg.req_valid = 1'b1; dbg.req_dump = dump; dbg.req_addr = addr;
    #1;
    while (!dbg.req_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got req_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    dbg.req_valid = 1'b0; dbg.req_dump = 1'b0; dbg.req_addr = 5'd0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int start_beats;
    rst_n = 1'b0;
    wb_rd = 5'd0; wb_pc = 64'h0; wb_data = 64'h0;
    dbg.req_valid = 1'b0; dbg.req_dump = 1'b0; dbg.req_addr = 5'd0;
    dbg.rsp_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
    chk("reset_rsp_addr",  64'(dbg.rsp_addr),  64'd0);
    chk("reset_rsp_data",  dbg.rsp_data,       64'd0);
    chk("reset_rsp_pc",    dbg.rsp_pc,         64'd0);
    chk("reset_rsp_last",  64'(dbg.rsp_last),  64'd0);
    chk("reset_dump_busy", 64'(dbg.dump_busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain write then read, one-cycle latency.
    wb_write(5'd7, 64'd8, 64'h1004);
    push(5'd7, 64'd8, 64'h1004, 1'b1, 1'b0);
    send_req(1'b0, 5'd7);
    chk("read_latency_valid", 64'(dbg.rsp_valid), 64'd1);

    // x0 ignores writes; never-written register reads as zero.
    wb_write(5'd0, 64'hdead, 64'h1008);
    push(5'd0, 64'h0, 64'h0, 1'b1, 1'b0);
    send_req(1'b0, 5'd0);
    push(5'd5, 64'h0, 64'h0, 1'b1, 1'b0);
    send_req(1'b0, 5'd5);

    // Same-cycle writeback and read go through the bypass.
    fork
      wb_write(5'd10, 64'h0a0b0c0d01020304, 64'h1014);
      begin
        push(5'd10, 64'h0a0b0c0d01020304, 64'h1014, 1'b1, 1'b0);
        send_req(1'b0, 5'd10);
      end
    join
    wait_drain(20);

    // Stall: outputs hold, no new request accepted.
    dbg.rsp_ready = 1'b0;
    push(5'd7, 64'd8, 64'h1004, 1'b1, 1'b0);
    send_req(1'b0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(dbg.rsp_valid), 64'd1);
      chk("stall_addr",  64'(dbg.rsp_addr),  64'd7);
      chk("stall_data",  dbg.rsp_data,       64'd8);
      chk("stall_pc",    dbg.rsp_pc,         64'h1004);
      chk("stall_req_ready", 64'(dbg.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    dbg.rsp_ready = 1'b1;
    dbg.req_valid = 1'b1; dbg.req_dump = 1'b0; dbg.req_addr = 5'd6;
    #1;
    chk("b2b_req_ready", 64'(dbg.req_ready), 64'd1);
    push(5'd6, 64'h0, 64'h0, 1'b1, 1'b0);
    send_req(1'b0, 5'd6);
    wait_drain(20);

    // Full dump with a random consumer and a live write to x20.
    start_beats = beats;
    send_req(1'b1, 5'd0);
    chk("dump_busy_start", 64'(dbg.dump_busy), 64'd1);
    wb_write(5'd20, 64'h2020_2020_abcd_0001, 64'h1050);
    push_dump();
    n = 0;
    while (beats < start_beats + 32 && n < 500) begin
      dbg.rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    dbg.rsp_ready = 1'b1;
    chk("dump_beat_count", 64'(beats - start_beats), 64'd32);
    wait_drain(20);
    chk("dump_busy_end", 64'(dbg.dump_busy), 64'd0);

    // Reset in the middle of a dump.
    push_dump();
    send_req(1'b1, 5'd0);
    n = 0;
    while (!(dbg.rsp_valid && dbg.rsp_addr == 5'd12) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat12", 64'(dbg.rsp_addr), 64'd12);
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    chk("midreset_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
    chk("midreset_dump_busy", 64'(dbg.dump_busy), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", 64'(dbg.rsp_valid), 64'd0);
    push(5'd7, 64'h0, 64'h0, 1'b1, 1'b0);
    send_req(1'b0, 5'd7);
    push_dump();
    send_req(1'b1, 5'd0);
    wait_drain(100);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
